// File: rtl/fp_pkg.sv
// Shared field constants, operand class codes and loader FSM states for the
// single-precision operand load path.
package fp_pkg;

  localparam int unsigned EXP_W   = 8;
  localparam int unsigned MAN_W   = 23;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  typedef enum logic [1:0] {
    CLS_NORM = 2'b00,
    CLS_ZERO = 2'b01,
    CLS_INF  = 2'b10,
    CLS_NAN  = 2'b11
  } cls_e;

  typedef enum logic [1:0] {
    S_WAIT_X = 2'd0,
    S_WAIT_Y = 2'd1,
    S_FIRE   = 2'd2,
    S_BUSY   = 2'd3
  } state_e;

endpackage

// File: rtl/fp_classify.sv
// Combinational IEEE-754 single-precision classifier; denormals count as zero
// and the sign bit never affects the class.
module fp_classify
  import fp_pkg::*;
(
  input  logic [31:0] word,
  output logic [1:0]  cls
);

  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] man_f;

  always_comb begin
    exp_f = word[MAN_W +: EXP_W];
    man_f = word[MAN_W-1:0];
    cls   = CLS_NORM;
    if (exp_f == EXP_MAX) begin
      cls = (man_f != '0) ? CLS_NAN : CLS_INF;
    end else if (exp_f == '0) begin
      cls = CLS_ZERO;
    end
  end

endmodule

// File: rtl/fp_operand_loader.sv
// Two-beat X/Y operand loader for the FP datapath: strobes the operand
// registers, records operand classes, starts the datapath and watches for DONE.
module fp_operand_loader
  import fp_pkg::*;
#(
  parameter int unsigned P   = 32,
  parameter int unsigned TMO = 64
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         IN_VALID,
  output logic         IN_READY,
  input  logic [P-1:0] IN_DATA,
  output logic [P-1:0] D_OUT,
  output logic         EN_X,
  output logic         EN_Y,
  output logic [1:0]   CLASS_X,
  output logic [1:0]   CLASS_Y,
  output logic         START,
  input  logic         DONE,
  output logic         BUSY,
  output logic         ERR
);

  localparam int unsigned TW = $clog2(TMO);

  state_e        state;
  logic [TW-1:0] timer;
  logic [1:0]    cls;

  fp_classify u_classify (
    .word (IN_DATA),
    .cls  (cls)
  );

  always_comb begin
    IN_READY = (state == S_WAIT_X) || (state == S_WAIT_Y);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= S_WAIT_X;
      timer   <= '0;
      D_OUT   <= '0;
      EN_X    <= 1'b0;
      EN_Y    <= 1'b0;
      CLASS_X <= CLS_NORM;
      CLASS_Y <= CLS_NORM;
      START   <= 1'b0;
      BUSY    <= 1'b0;
      ERR     <= 1'b0;
    end else begin
      EN_X  <= 1'b0;
      EN_Y  <= 1'b0;
      START <= 1'b0;
      ERR   <= 1'b0;
      case (state)
        S_WAIT_X: begin
          if (IN_VALID) begin
            D_OUT   <= IN_DATA;
            EN_X    <= 1'b1;
            CLASS_X <= cls;
            state   <= S_WAIT_Y;
          end
        end
        S_WAIT_Y: begin
          if (IN_VALID) begin
            D_OUT   <= IN_DATA;
            EN_Y    <= 1'b1;
            CLASS_Y <= cls;
            BUSY    <= 1'b1;
            state   <= S_FIRE;
          end
        end
        S_FIRE: begin
          START <= 1'b1;
          timer <= '0;
          state <= S_BUSY;
        end
        S_BUSY: begin
          // DONE is checked first so it beats a simultaneous watchdog expiry
          if (DONE) begin
            BUSY  <= 1'b0;
            state <= S_WAIT_X;
          end else if (timer == TW'(TMO - 1)) begin
            ERR   <= 1'b1;
            BUSY  <= 1'b0;
            state <= S_WAIT_X;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= S_WAIT_X;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_operand_loader.sv
// Directed bench for fp_operand_loader with a short watchdog (TMO=8).
module tb_fp_operand_loader;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [31:0] IN_DATA = '0;
  logic [31:0] D_OUT;
  logic        EN_X, EN_Y;
  logic [1:0]  CLASS_X, CLASS_Y;
  logic        START;
  logic        DONE = 1'b0;
  logic        BUSY;
  logic        ERR;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  fp_operand_loader #(.P(32), .TMO(8)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .IN_VALID (IN_VALID),
    .IN_READY (IN_READY),
    .IN_DATA  (IN_DATA),
    .D_OUT    (D_OUT),
    .EN_X     (EN_X),
    .EN_Y     (EN_Y),
    .CLASS_X  (CLASS_X),
    .CLASS_Y  (CLASS_Y),
    .START    (START),
    .DONE     (DONE),
    .BUSY     (BUSY),
    .ERR      (ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Advance one edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_x(input logic [31:0] x, input logic [1:0] cx);
    IN_VALID = 1'b1;
    IN_DATA  = x;
    check("rdy_x", 32'(IN_READY), 32'd1);
    tick();
    IN_VALID = 1'b0;
    check("en_x", 32'(EN_X), 32'd1);
    check("en_y_lo", 32'(EN_Y), 32'd0);
    check("dout_x", D_OUT, x);
    check("class_x", 32'(CLASS_X), 32'(cx));
    check("rdy_wy", 32'(IN_READY), 32'd1);
  endtask

  task automatic send_y(input logic [31:0] y, input logic [1:0] cy);
    IN_VALID = 1'b1;
    IN_DATA  = y;
    tick();
    IN_VALID = 1'b0;
    check("en_y", 32'(EN_Y), 32'd1);
    check("en_x_lo", 32'(EN_X), 32'd0);
    check("dout_y", D_OUT, y);
    check("class_y", 32'(CLASS_Y), 32'(cy));
    check("busy_fire", 32'(BUSY), 32'd1);
    check("rdy_fire", 32'(IN_READY), 32'd0);
    tick();
    check("start", 32'(START), 32'd1);
    check("busy_start", 32'(BUSY), 32'd1);
  endtask

  task automatic finish_done();
    DONE = 1'b1;
    tick();
    DONE = 1'b0;
    check("done_busy", 32'(BUSY), 32'd0);
    check("done_rdy", 32'(IN_READY), 32'd1);
    check("done_err", 32'(ERR), 32'd0);
  endtask

  initial begin
    tick();
    tick();
    check("rst_dout", D_OUT, 32'h0);
    check("rst_en", {30'd0, EN_X, EN_Y}, 32'd0);
    check("rst_flags", {29'd0, START, BUSY, ERR}, 32'd0);
    check("rst_class", {28'd0, CLASS_X, CLASS_Y}, 32'd0);
    check("rst_rdy", 32'(IN_READY), 32'd1);
    RST = 1'b0;

    // Basic load of 1.0 and 2.0, back-to-back beats
    send_x(32'h3F800000, 2'b00);
    send_y(32'h40000000, 2'b00);
    tick();
    check("start_pulse", 32'(START), 32'd0);
    finish_done();

    // Special operands; CLASS_Y must hold across the next X load
    send_x(32'h7F800000, 2'b10);
    send_y(32'h7FC00001, 2'b11);
    finish_done();
    send_x(32'h80000001, 2'b01);
    check("class_y_hold", 32'(CLASS_Y), 32'd3);
    send_y(32'h00000000, 2'b01);
    finish_done();

    // Backpressure: word held pending during FIRE/BUSY becomes the next X
    send_x(32'h3F000000, 2'b00);
    IN_VALID = 1'b1;
    IN_DATA  = 32'h40400000;
    tick();
    check("en_y_bp", 32'(EN_Y), 32'd1);
    for (int unsigned i = 0; i < 3; i++) begin
      check("rdy_bp", 32'(IN_READY), 32'd0);
      tick();
    end
    IN_DATA = 32'hFF800000;
    check("rdy_bp2", 32'(IN_READY), 32'd0);
    DONE = 1'b1;
    tick();
    DONE = 1'b0;
    check("bp_rdy", 32'(IN_READY), 32'd1);
    check("bp_no_en", {30'd0, EN_X, EN_Y}, 32'd0);
    tick();
    IN_VALID = 1'b0;
    check("bp_en_x", 32'(EN_X), 32'd1);
    check("bp_dout", D_OUT, 32'hFF800000);
    check("bp_class", 32'(CLASS_X), 32'd2);
    tick();
    check("bp_no_dup", {30'd0, EN_X, EN_Y}, 32'd0);
    check("bp_wait_y", 32'(IN_READY), 32'd1);
    send_y(32'h3F800000, 2'b00);
    finish_done();

    // Timeout: ERR exactly 8 cycles after START
    send_x(32'h3F800000, 2'b00);
    send_y(32'h3F800000, 2'b00);
    for (int unsigned i = 1; i < 8; i++) begin
      tick();
      check("tmo_wait", {30'd0, ERR, BUSY}, 32'd1);
    end
    tick();
    check("tmo_err", 32'(ERR), 32'd1);
    check("tmo_busy", 32'(BUSY), 32'd0);
    check("tmo_rdy", 32'(IN_READY), 32'd1);
    tick();
    check("tmo_err_pulse", 32'(ERR), 32'd0);

    // DONE in the expiry cycle wins
    send_x(32'h3F800000, 2'b00);
    send_y(32'h3F800000, 2'b00);
    for (int unsigned i = 1; i < 8; i++) tick();
    check("tmo2_busy", {30'd0, ERR, BUSY}, 32'd1);
    finish_done();

    // Reset mid-BUSY with a DONE pending
    send_x(32'h12345678, 2'b00);
    send_y(32'h7F800001, 2'b11);
    for (int unsigned i = 0; i < 3; i++) tick();
    RST  = 1'b1;
    DONE = 1'b1;
    tick();
    RST  = 1'b0;
    DONE = 1'b0;
    check("mrst_dout", D_OUT, 32'h0);
    check("mrst_flags", {27'd0, EN_X, EN_Y, START, BUSY, ERR}, 32'd0);
    check("mrst_class", {28'd0, CLASS_X, CLASS_Y}, 32'd0);
    check("mrst_rdy", 32'(IN_READY), 32'd1);
    for (int unsigned i = 0; i < 10; i++) begin
      tick();
      check("mrst_idle", {29'd0, START, BUSY, ERR}, 32'd0);
    end
    send_x(32'h40490FDB, 2'b00);
    send_y(32'h00400000, 2'b01);
    finish_done();

    // Stray DONE in WAIT_X and WAIT_Y
    DONE = 1'b1;
    tick();
    DONE = 1'b0;
    check("stray_x", {28'd0, EN_X, EN_Y, START, ERR}, 32'd0);
    check("stray_x_rdy", 32'(IN_READY), 32'd1);
    send_x(32'h3F800000, 2'b00);
    DONE = 1'b1;
    tick();
    DONE = 1'b0;
    check("stray_y", {27'd0, EN_X, EN_Y, START, BUSY, ERR}, 32'd0);
    check("stray_y_rdy", 32'(IN_READY), 32'd1);
    send_y(32'h40000000, 2'b00);
    finish_done();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
